// File: rtl/alu_wb_pkg.sv
// Shared constants and types for the ALU writeback stage.
// Holds FIFO depth, flag bit positions, select codes and the arithmetic range.
package alu_wb_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int DATA_W     = 64;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic [3:0] SEL_00 = 4'd0;
  localparam logic [3:0] SEL_01 = 4'd1;
  localparam logic [3:0] SEL_02 = 4'd2;
  localparam logic [3:0] SEL_03 = 4'd3;
  localparam logic [3:0] SEL_04 = 4'd4;
  localparam logic [3:0] SEL_05 = 4'd5;
  localparam logic [3:0] SEL_06 = 4'd6;
  localparam logic [3:0] SEL_07 = 4'd7;
  localparam logic [3:0] SEL_08 = 4'd8;
  localparam logic [3:0] SEL_09 = 4'd9;
  localparam logic [3:0] SEL_10 = 4'd10;
  localparam logic [3:0] SEL_11 = 4'd11;
  localparam logic [3:0] SEL_12 = 4'd12;
  localparam logic [3:0] SEL_13 = 4'd13;
  localparam logic [3:0] SEL_14 = 4'd14;
  localparam logic [3:0] SEL_15 = 4'd15;

  localparam logic [3:0] ARITH_LO = SEL_02;
  localparam logic [3:0] ARITH_HI = SEL_07;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [3:0]        op;
    logic [3:0]        flags;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  function automatic logic is_arith(input logic [3:0] sel);
    return (sel >= ARITH_LO) && (sel <= ARITH_HI);
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Synchronous FIFO with registered occupancy; no pass-through when full.
// Push is ignored while full, pop is ignored while empty.
module alu_wb_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == {LVL_W{1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      level  <= {LVL_W{1'b0}};
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers results and tracks carry, flags, drops and overflows.
// Optional overflow counter enabled by defining ALU_WB_OVF_CNT_EN.
module alu_writeback
  import alu_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] alu_o,
  input  logic [3:0]  alu_s,
  input  logic        alu_cout,
  input  logic        alu_oflow,
  input  logic        alu_ntive,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_op,
  output logic [3:0]  out_flags,
  output logic        carry_q,
  output logic [3:0]  flags_q,
  output logic [2:0]  level,
  output logic        drop_err,
  output logic [15:0] ovf_cnt
);

  logic         full;
  logic         empty;
  logic         push;
  logic [3:0]   flags_in;
  wb_entry_t    wr_entry;
  wb_entry_t    rd_entry;

  // pack incoming flags into {C,V,N,Z}
  always_comb begin
    flags_in         = 4'b0000;
    flags_in[FLAG_C] = alu_cout;
    flags_in[FLAG_V] = alu_oflow;
    flags_in[FLAG_N] = alu_ntive;
    flags_in[FLAG_Z] = alu_zero;
  end

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign wr_entry = '{data: alu_o, op: alu_s, flags: flags_in};

  alu_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_data  = rd_entry.data;
  assign out_op    = rd_entry.op;
  assign out_flags = rd_entry.flags;

  // carry chain, last flags and sticky drop indicator
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q  <= 1'b0;
      flags_q  <= 4'b0000;
      drop_err <= 1'b0;
    end else begin
      if (push) begin
        flags_q <= flags_in;
        if (is_arith(alu_s)) carry_q <= alu_cout;
      end
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end

`ifdef ALU_WB_OVF_CNT_EN
  // saturating count of accepted overflowing results
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= 16'h0000;
    end else if (push && alu_oflow && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'h0001;
    end
  end
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_writeback;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_o;
  logic [3:0]  alu_s;
  logic        alu_cout, alu_oflow, alu_ntive, alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_op;
  logic [3:0]  out_flags;
  logic        carry_q;
  logic [3:0]  flags_q;
  logic [2:0]  level;
  logic        drop_err;
  logic [15:0] ovf_cnt;

  alu_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_o(alu_o), .alu_s(alu_s), .alu_cout(alu_cout), .alu_oflow(alu_oflow),
    .alu_ntive(alu_ntive), .alu_zero(alu_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
    .out_flags(out_flags), .carry_q(carry_q), .flags_q(flags_q),
    .level(level), .drop_err(drop_err), .ovf_cnt(ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  op;
    logic [3:0]  f;
  } ent_t;

  ent_t        mq[$];
  logic        mcarry;
  logic [3:0]  mflags;
  logic        mdrop;
  int          movf;
  int          checks;
  int          passed;

  // drive one cycle of inputs, advance the reference model, then sample 1 time unit after the edge
  task automatic drive(input bit r, input bit iv, input bit ordy, input logic [3:0] s,
                       input logic [63:0] d, input logic [3:0] f);
    ent_t e;
    bit   can_push;
    rst = r; in_valid = iv; out_ready = ordy; alu_s = s; alu_o = d;
    {alu_cout, alu_oflow, alu_ntive, alu_zero} = f;
    if (r) begin
      mq.delete(); mcarry = 1'b0; mflags = 4'h0; mdrop = 1'b0; movf = 0;
    end else begin
      can_push = iv && (mq.size() < 4);
      if (iv && !can_push) mdrop = 1'b1;
      if (ordy && mq.size() > 0) void'(mq.pop_front());
      if (can_push) begin
        e.d = d; e.op = s; e.f = f;
        mq.push_back(e);
        mflags = f;
        if (s >= 4'd2 && s <= 4'd7) mcarry = f[3];
`ifdef ALU_WB_OVF_CNT_EN
        if (f[2] && movf < 65535) movf++;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 4'h0);
    drive(1'b1, 1'b1, 1'b1, 4'd3, 64'd5, 4'hF);
    checks++; if (level !== 3'd0)     $display("FAIL reset_level: got %0d want 0", level); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (carry_q !== 1'b0)   $display("FAIL reset_carry: got %b want 0", carry_q); else passed++;
    checks++; if (flags_q !== 4'h0)   $display("FAIL reset_flags: got %h want 0", flags_q); else passed++;
    checks++; if (drop_err !== 1'b0)  $display("FAIL reset_drop: got %b want 0", drop_err); else passed++;
    checks++; if (ovf_cnt !== 16'h0)  $display("FAIL reset_ovf: got %0d want 0", ovf_cnt); else passed++;
  endtask

  task automatic test_first_push();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 4'd2, 64'h1, 4'b1000);
    checks++; if (out_valid !== 1'b1) $display("FAIL first_out_valid: got %b want 1", out_valid); else passed++;
    checks++; if (out_data !== 64'h1) $display("FAIL first_out_data: got %h want 1", out_data); else passed++;
    checks++; if (out_op !== 4'd2)    $display("FAIL first_out_op: got %0d want 2", out_op); else passed++;
    checks++; if (carry_q !== 1'b1)   $display("FAIL first_carry: got %b want 1", carry_q); else passed++;
    checks++; if (flags_q[3] !== 1'b1) $display("FAIL first_flag_c: got %b want 1", flags_q[3]); else passed++;
    drive(1'b0, 1'b0, 1'b1, 4'd0, 64'd0, 4'h0);
    checks++; if (out_valid !== 1'b0) $display("FAIL first_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_full_drop();
    logic [3:0] saved;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 4'h0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 1'b0, 4'(i + 3), {$urandom, $urandom}, 4'(i + 1));
    saved = mflags;
    checks++; if (level !== 3'd4)    $display("FAIL full_level: got %0d want 4", level); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else passed++;
    drive(1'b0, 1'b1, 1'b0, 4'd5, 64'hDEAD, 4'hE);
    checks++; if (drop_err !== 1'b1) $display("FAIL drop_err: got %b want 1", drop_err); else passed++;
    checks++; if (level !== 3'd4)    $display("FAIL drop_level: got %0d want 4", level); else passed++;
    checks++; if (flags_q !== saved) $display("FAIL drop_flags: got %h want %h", flags_q, saved); else passed++;
    while (mq.size() > 0) begin
      checks++;
      if (out_data !== mq[0].d || out_flags !== mq[0].f)
        $display("FAIL drain_order: got %h/%h want %h/%h", out_data, out_flags, mq[0].d, mq[0].f);
      else passed++;
      drive(1'b0, 1'b0, 1'b1, 4'd0, 64'd0, 4'h0);
    end
    checks++; if (drop_err !== 1'b1) $display("FAIL drop_sticky: got %b want 1", drop_err); else passed++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 4'd10, {$urandom, $urandom}, 4'h1);
    drive(1'b0, 1'b1, 1'b0, 4'd11, {$urandom, $urandom}, 4'h2);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), {$urandom, $urandom}, 4'($urandom));
      checks++; if (level !== 3'd2) $display("FAIL b2b_level: got %0d want 2", level); else passed++;
      checks++;
      if (out_data !== mq[0].d || out_op !== mq[0].op)
        $display("FAIL b2b_order: got %h/%0d want %h/%0d", out_data, out_op, mq[0].d, mq[0].op);
      else passed++;
    end
  endtask

  task automatic test_carry();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 4'h0);
    drive(1'b0, 1'b1, 1'b1, 4'd2, 64'd1, 4'b1000);
    checks++; if (carry_q !== 1'b1) $display("FAIL carry_set: got %b want 1", carry_q); else passed++;
    drive(1'b0, 1'b1, 1'b1, 4'd9, 64'd2, 4'b0001);
    checks++; if (carry_q !== 1'b1) $display("FAIL carry_hold_and: got %b want 1", carry_q); else passed++;
    checks++; if (flags_q !== 4'b0001) $display("FAIL carry_and_flags: got %h want 1", flags_q); else passed++;
    drive(1'b0, 1'b1, 1'b1, 4'd7, 64'd3, 4'b0000);
    checks++; if (carry_q !== 1'b0) $display("FAIL carry_sel7: got %b want 0", carry_q); else passed++;
    drive(1'b0, 1'b1, 1'b1, 4'd8, 64'd4, 4'b1000);
    checks++; if (carry_q !== 1'b0) $display("FAIL carry_sel8: got %b want 0", carry_q); else passed++;
    drive(1'b0, 1'b1, 1'b1, 4'd1, 64'd5, 4'b1000);
    checks++; if (carry_q !== 1'b0) $display("FAIL carry_sel1: got %b want 0", carry_q); else passed++;
  endtask

  task automatic test_ovf();
    logic [15:0] want;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 4'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 4'd4, 64'(i), 4'b0100);
    drive(1'b0, 1'b1, 1'b1, 4'd4, 64'd9, 4'b0000);
`ifdef ALU_WB_OVF_CNT_EN
    want = 16'd3;
`else
    want = 16'd0;
`endif
    checks++; if (ovf_cnt !== want) $display("FAIL ovf_cnt: got %0d want %0d", ovf_cnt, want); else passed++;
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 4'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 4'd3, 64'(i + 100), 4'b1000);
    drive(1'b0, 1'b0, 1'b1, 4'd0, 64'd0, 4'h0);
    checks++; if (level !== 3'd3 || drop_err !== 1'b1 || carry_q !== 1'b1)
      $display("FAIL mid_pre: got lvl %0d drop %b carry %b want 3 1 1", level, drop_err, carry_q); else passed++;
    drive(1'b1, 1'b0, 1'b1, 4'd0, 64'd0, 4'h0);
    checks++; if (level !== 3'd0)     $display("FAIL mid_level: got %0d want 0", level); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (carry_q !== 1'b0)   $display("FAIL mid_carry: got %b want 0", carry_q); else passed++;
    checks++; if (drop_err !== 1'b0)  $display("FAIL mid_drop: got %b want 0", drop_err); else passed++;
  endtask

  task automatic test_random();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 4'h0);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), {$urandom, $urandom}, 4'($urandom));
      checks++;
      if (level !== 3'(mq.size()) || out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 4))
        $display("FAIL rnd_state: got lvl %0d ov %b ir %b want lvl %0d", level, out_valid, in_ready, mq.size());
      else passed++;
      checks++;
      if (carry_q !== mcarry || flags_q !== mflags || drop_err !== mdrop || ovf_cnt !== 16'(movf))
        $display("FAIL rnd_regs: got c%b f%h d%b o%0d want c%b f%h d%b o%0d",
                 carry_q, flags_q, drop_err, ovf_cnt, mcarry, mflags, mdrop, movf);
      else passed++;
      if (mq.size() > 0) begin
        checks++;
        if (out_data !== mq[0].d || out_op !== mq[0].op || out_flags !== mq[0].f)
          $display("FAIL rnd_head: got %h/%0d/%h want %h/%0d/%h",
                   out_data, out_op, out_flags, mq[0].d, mq[0].op, mq[0].f);
        else passed++;
      end
    end
  endtask

  initial begin
    checks = 0; passed = 0;
    mcarry = 1'b0; mflags = 4'h0; mdrop = 1'b0; movf = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_o = 64'd0; alu_s = 4'd0;
    alu_cout = 1'b0; alu_oflow = 1'b0; alu_ntive = 1'b0; alu_zero = 1'b0;
    test_reset();
    test_first_push();
    test_full_drop();
    test_back_to_back();
    test_carry();
    test_ovf();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL expose ports: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  ALU result present this cycle.
REQ-005 in_ready  out  1  stage can accept a result.
REQ-006 alu_o  in  64  ALU result.
REQ-007 alu_s  in  4  ALU select code that produced alu_o.
REQ-008 alu_cout, alu_oflow, alu_ntive, alu_zero  in  1 each  ALU flags.
REQ-009 out_valid  out  1  head entry valid.
REQ-010 out_ready  in  1  consumer takes head.
REQ-011 out_data  out  64  head result.
REQ-012 out_op  out  4  head select code.
REQ-013 out_flags  out  4  head flags {C,V,N,Z}.
REQ-014 carry_q  out  1  registered carry, drives ALU Cin for chained multi-word ops.
REQ-015 flags_q  out  4  last accepted flags {C,V,N,Z}.
REQ-016 level  out  3  FIFO occupancy, 0..4.
REQ-017 drop_err  out  1  sticky: result offered while full.
REQ-018 ovf_cnt  out  16  overflow-event count (see Configuration).

Function
REQ-019 SHALL buffer results in a 4-entry FIFO of {data 64, op 4, flags 4}.
REQ-020 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-021 in_ready SHALL be 1 iff level<4; there is no pass-through on full, even with a same-cycle pop.
REQ-022 out_valid SHALL be 1 iff level>0; out_data, out_op and out_flags SHALL show the head entry; they are don't-care when level==0.
REQ-023 Latency: a push into an empty FIFO SHALL give out_valid=1 in the next cycle; there is no combinational path from the in_* inputs to the out_* outputs.
REQ-024 A simultaneous push and pop with 1<=level<=3 SHALL leave level unchanged and preserve FIFO order.
REQ-025 Read and write pointers SHALL be 2 bits and wrap 3->0.
REQ-026 On push with alu_s in 2..7 (arithmetic), carry_q SHALL load alu_cout; on push with any other code, carry_q SHALL hold its value.
REQ-027 On every push, flags_q SHALL load {alu_cout, alu_oflow, alu_ntive, alu_zero}.
REQ-028 in_valid && !in_ready SHALL discard the result, leave carry_q and flags_q unchanged, and set drop_err, which stays 1 until reset.
REQ-029 Pop on empty SHALL be ignored, and level SHALL never underflow.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL clear: level=0, pointers=0, out_valid=0, in_ready=1, carry_q=0, flags_q=0, drop_err=0, ovf_cnt=0.
REQ-031 Reset asserted mid-stream SHALL discard all buffered entries with no partial pop.
REQ-032 Stored FIFO data need not be cleared by reset.

Configuration
REQ-033 Macro ALU_WB_OVF_CNT_EN SHALL gate the overflow counter.
REQ-034 With ALU_WB_OVF_CNT_EN defined, ovf_cnt SHALL increment on each push with alu_oflow=1 and saturate at 16'hFFFF.
REQ-035 Without ALU_WB_OVF_CNT_EN, ovf_cnt SHALL be constant 0, no counter logic SHALL exist, and the port list SHALL be unchanged.

Structure
REQ-036 A shared package SHALL hold: the FIFO depth constant (4), the flag bit indices (C=3, V=2, N=1, Z=0), the select-code constants 0..15, and the arithmetic range bounds (2, 7).
REQ-037 The FIFO SHALL be one sub-module, alu_wb_fifo, parameterised on width and depth.
REQ-038 Flag, carry and counter logic SHALL live in the top level.

Verification
REQ-039 Reset, then push alu_o=64'h1, alu_s=2, cout=1 -> next cycle: out_valid=1, out_data=1, carry_q=1, flags_q[3]=1.
REQ-040 Push 4 results with out_ready=0 -> level=4, in_ready=0; a 5th push sets drop_err=1, level stays 4, flags_q unchanged.
REQ-041 level=2, push and pop in the same cycle -> level stays 2; the output sequence matches the input order across a pointer wrap.
REQ-042 Push alu_s=9 (AND) with cout=0 after carry_q=1 -> carry_q stays 1.
REQ-043 With ALU_WB_OVF_CNT_EN defined, 3 pushes with oflow=1 -> ovf_cnt=3; without the macro -> ovf_cnt=0.
REQ-044 Assert rst with level=3 -> next cycle: level=0, out_valid=0, carry_q=0, drop_err=0.
